// File: rtl/ir_pkg.sv
// NEC IR protocol constants shared by the transmitter and receiver.
// Cycle counts assume a 27 MHz clock.
package ir_pkg;

  localparam int unsigned NEC_LEAD_MARK_CYC  = 243000;
  localparam int unsigned NEC_LEAD_SPACE_CYC = 121500;
  localparam int unsigned NEC_RPT_SPACE_CYC  = 60750;
  localparam int unsigned NEC_BIT_MARK_CYC   = 15188;
  localparam int unsigned NEC_ZERO_SPACE_CYC = 15188;
  localparam int unsigned NEC_ONE_SPACE_CYC  = 45563;
  localparam int unsigned NEC_FRAME_CYC      = 2916000;
  localparam int unsigned NEC_CARRIER_CYC    = 711;
  localparam int unsigned NEC_CARRIER_HI_CYC = 237;

  localparam int unsigned NEC_BITS  = 32;
  localparam int unsigned SEG_W     = 18;
  localparam int unsigned FRAME_W   = 22;
  localparam int unsigned BIT_IDX_W = 5;
  localparam int unsigned CARRIER_W = 10;

  // Over-the-air word: {addr, ~addr, cmd, ~cmd}, sent MSB first.
  function automatic logic [31:0] nec_word(input logic [15:0] code);
    return {code[15:8], ~code[15:8], code[7:0], ~code[7:0]};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: high for the first CARRIER_HI_CYC cycles of each period while enabled.
// Dropping enable resets the phase so every mark starts on a fresh carrier period.
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int unsigned CARRIER_CYC    = NEC_CARRIER_CYC,
  parameter int unsigned CARRIER_HI_CYC = NEC_CARRIER_HI_CYC
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic enable,
  output logic carrier
);

  logic [CARRIER_W-1:0] r_cnt;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (r_cnt == CARRIER_W'(CARRIER_CYC - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CARRIER_W'(1);
    end
  end

  assign carrier = enable && (r_cnt < CARRIER_W'(CARRIER_HI_CYC));

endmodule

// File: rtl/ir_tx.sv
// NEC IR transmitter: frame (lead, 32 bits, stop) then repeat codes while the key is held.
// ir_tx_n is the registered demodulated level; ir_led adds the carrier during marks.
module ir_tx
  import ir_pkg::*;
#(
  parameter int unsigned LEAD_MARK_CYC  = NEC_LEAD_MARK_CYC,
  parameter int unsigned LEAD_SPACE_CYC = NEC_LEAD_SPACE_CYC,
  parameter int unsigned RPT_SPACE_CYC  = NEC_RPT_SPACE_CYC,
  parameter int unsigned BIT_MARK_CYC   = NEC_BIT_MARK_CYC,
  parameter int unsigned ZERO_SPACE_CYC = NEC_ZERO_SPACE_CYC,
  parameter int unsigned ONE_SPACE_CYC  = NEC_ONE_SPACE_CYC,
  parameter int unsigned FRAME_CYC      = NEC_FRAME_CYC,
  parameter int unsigned CARRIER_CYC    = NEC_CARRIER_CYC,
  parameter int unsigned CARRIER_HI_CYC = NEC_CARRIER_HI_CYC
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [15:0] tx_code,
  input  logic        tx_start,
  input  logic        tx_hold,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        ir_tx_n,
  output logic        ir_led
);

  typedef enum logic [3:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap,
    StRptMark,
    StRptSpace,
    StRptStop
  } state_e;

  state_e               r_state;
  logic [31:0]          r_word;
  logic [SEG_W-1:0]     r_seg_cnt;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 r_tx_busy;
  logic                 r_tx_done;
  logic                 r_ir_tx_n;

  logic                 w_cur_bit;
  logic [SEG_W-1:0]     w_seg_max;
  logic                 w_seg_last;
  logic                 w_frame_last;
  logic                 w_carrier;

  // Bit index counts up from 0 while bits go out word[31] first, so invert it.
  assign w_cur_bit = r_word[~r_bit_idx];

  always_comb begin
    w_seg_max = SEG_W'(BIT_MARK_CYC - 1);
    case (r_state)
      StLeadMark, StRptMark: w_seg_max = SEG_W'(LEAD_MARK_CYC - 1);
      StLeadSpace:           w_seg_max = SEG_W'(LEAD_SPACE_CYC - 1);
      StBitSpace:            w_seg_max = w_cur_bit ? SEG_W'(ONE_SPACE_CYC - 1)
                                                   : SEG_W'(ZERO_SPACE_CYC - 1);
      StRptSpace:            w_seg_max = SEG_W'(RPT_SPACE_CYC - 1);
      default:               ;
    endcase
  end

  assign w_seg_last   = (r_seg_cnt == w_seg_max);
  assign w_frame_last = (r_frame_cnt >= FRAME_W'(FRAME_CYC - 1));

  // Outputs are assigned on the same edge as the state they belong to.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_word      <= '0;
      r_seg_cnt   <= '0;
      r_frame_cnt <= '0;
      r_bit_idx   <= '0;
      r_tx_busy   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_ir_tx_n   <= 1'b1;
    end else begin
      r_tx_done <= 1'b0;
      if (r_state != StIdle) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
      if (r_state != StIdle && r_state != StGap) begin
        r_seg_cnt <= w_seg_last ? '0 : r_seg_cnt + SEG_W'(1);
      end

      case (r_state)
        StIdle: begin
          if (tx_start) begin
            r_word      <= nec_word(tx_code);
            r_frame_cnt <= '0;
            r_seg_cnt   <= '0;
            r_bit_idx   <= '0;
            r_tx_busy   <= 1'b1;
            r_ir_tx_n   <= 1'b0;
            r_state     <= StLeadMark;
          end
        end
        StLeadMark: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b1;
            r_state   <= StLeadSpace;
          end
        end
        StLeadSpace: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b0;
            r_state   <= StBitMark;
          end
        end
        StBitMark: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b1;
            r_state   <= StBitSpace;
          end
        end
        StBitSpace: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b0;
            if (r_bit_idx == BIT_IDX_W'(NEC_BITS - 1)) begin
              r_bit_idx <= '0;
              r_state   <= StStopMark;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
              r_state   <= StBitMark;
            end
          end
        end
        StStopMark: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b1;
            r_state   <= StGap;
          end
        end
        StGap: begin
          if (w_frame_last) begin
            r_frame_cnt <= '0;
            if (tx_hold) begin
              r_ir_tx_n <= 1'b0;
              r_state   <= StRptMark;
            end else begin
              r_tx_busy <= 1'b0;
              r_tx_done <= 1'b1;
              r_state   <= StIdle;
            end
          end
        end
        StRptMark: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b1;
            r_state   <= StRptSpace;
          end
        end
        StRptSpace: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b0;
            r_state   <= StRptStop;
          end
        end
        StRptStop: begin
          if (w_seg_last) begin
            r_ir_tx_n <= 1'b1;
            r_state   <= StGap;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  ir_carrier_gen #(
    .CARRIER_CYC    (CARRIER_CYC),
    .CARRIER_HI_CYC (CARRIER_HI_CYC)
  ) u_carrier (
    .clk27   (clk27),
    .reset_n (reset_n),
    .enable  (~r_ir_tx_n),
    .carrier (w_carrier)
  );

  assign tx_busy = r_tx_busy;
  assign tx_done = r_tx_done;
  assign ir_tx_n = r_ir_tx_n;
  assign ir_led  = w_carrier;

endmodule
